// File: rtl/llc_stall_ctrl.sv
// LLC stall state: reset/flush set-walk FSM and single-entry stalled-request buffer with replay.
// Optional LLC_STALL_STATS_EN adds a saturating stall_cycles counter.
module llc_stall_ctrl #(
  parameter int unsigned SET_BITS = 9,
  parameter int unsigned TAG_BITS = 15,
  parameter int unsigned REQ_W    = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_rst,
  input  logic                start_flush,
  input  logic                incr_rst_flush_stalled_set,
  input  logic                clr_rst_stall,
  input  logic                clr_flush_stall,
  input  logic                set_req_stall,
  input  logic [SET_BITS-1:0] stall_set,
  input  logic [TAG_BITS-1:0] stall_tag,
  input  logic [REQ_W-1:0]    stall_payload,
  input  logic                clr_req_stall,
  input  logic                update_req_in_from_stalled,
  output logic                rst_stall,
  output logic                flush_stall,
  output logic [SET_BITS-1:0] rst_flush_stalled_set,
  output logic                rst_flush_done,
  output logic                req_stall,
  output logic                req_in_stalled_valid,
  output logic [SET_BITS-1:0] req_in_stalled_set,
  output logic [TAG_BITS-1:0] req_in_stalled_tag,
  output logic [REQ_W-1:0]    req_in_stalled_payload,
  output logic                err
`ifdef LLC_STALL_STATS_EN
  ,
  output logic [15:0]         stall_cycles
`endif
);

  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_RST   = 2'd1;
  localparam logic [1:0] W_FLUSH = 2'd2;

  localparam logic [1:0] R_IDLE   = 2'd0;
  localparam logic [1:0] R_STALL  = 2'd1;
  localparam logic [1:0] R_REPLAY = 2'd2;

  localparam logic [SET_BITS-1:0] SetOne = SET_BITS'(1);

  logic [1:0]          walk_q, walk_d;
  logic [SET_BITS-1:0] cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                walk_err;
  logic [1:0]          req_q, req_d;
  logic [SET_BITS-1:0] set_q, set_d;
  logic [TAG_BITS-1:0] tag_q, tag_d;
  logic [REQ_W-1:0]    payload_q, payload_d;
  logic                req_err;
  logic                err_q, err_d;

  always_comb begin
    walk_d   = walk_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    walk_err = 1'b0;
    case (walk_q)
      W_IDLE: begin
        // start_rst has priority; a simultaneous start_flush is a protocol error
        if (start_rst) begin
          walk_d   = W_RST;
          cnt_d    = '0;
          walk_err = start_flush;
        end else if (start_flush) begin
          walk_d = W_FLUSH;
          cnt_d  = '0;
        end
      end
      W_RST: begin
        walk_err = start_rst | start_flush;
        if (incr_rst_flush_stalled_set) cnt_d = cnt_q + SetOne;
        if (clr_rst_stall) begin
          walk_d = W_IDLE;
          done_d = 1'b1;
        end
      end
      W_FLUSH: begin
        walk_err = start_rst | start_flush;
        if (incr_rst_flush_stalled_set) cnt_d = cnt_q + SetOne;
        if (clr_flush_stall) begin
          walk_d = W_IDLE;
          done_d = 1'b1;
        end
      end
      default: walk_d = W_IDLE;
    endcase
  end

  always_comb begin
    req_d     = req_q;
    set_d     = set_q;
    tag_d     = tag_q;
    payload_d = payload_q;
    req_err   = 1'b0;
    case (req_q)
      R_IDLE: begin
        if (set_req_stall) begin
          req_d     = R_STALL;
          set_d     = stall_set;
          tag_d     = stall_tag;
          payload_d = stall_payload;
        end
      end
      R_STALL: begin
        req_err = set_req_stall;
        if (clr_req_stall) req_d = R_REPLAY;
      end
      R_REPLAY: begin
        req_err = set_req_stall;
        if (update_req_in_from_stalled) req_d = R_IDLE;
      end
      default: req_d = R_IDLE;
    endcase
  end

  assign err_d = err_q | walk_err | req_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      walk_q    <= W_IDLE;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      req_q     <= R_IDLE;
      set_q     <= '0;
      tag_q     <= '0;
      payload_q <= '0;
      err_q     <= 1'b0;
    end else begin
      walk_q    <= walk_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      req_q     <= req_d;
      set_q     <= set_d;
      tag_q     <= tag_d;
      payload_q <= payload_d;
      err_q     <= err_d;
    end
  end

  assign rst_stall              = (walk_q == W_RST);
  assign flush_stall            = (walk_q == W_FLUSH);
  assign rst_flush_stalled_set  = cnt_q;
  assign rst_flush_done         = done_q;
  assign req_stall              = (req_q == R_STALL);
  assign req_in_stalled_valid   = (req_q == R_REPLAY);
  assign req_in_stalled_set     = set_q;
  assign req_in_stalled_tag     = tag_q;
  assign req_in_stalled_payload = payload_q;
  assign err                    = err_q;

`ifdef LLC_STALL_STATS_EN
  logic [15:0] stats_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stats_q <= '0;
    end else if ((req_q == R_STALL) && (stats_q != 16'hFFFF)) begin
      stats_q <= stats_q + 16'd1;
    end
  end

  assign stall_cycles = stats_q;
`endif

endmodule

// File: tb/tb_llc_stall_ctrl.sv
// Self-checking bench for llc_stall_ctrl: vector table, hand sequences for corner cases,
// and randomized traffic against a behavioural model.
module tb_llc_stall_ctrl;

  localparam logic [7:0] C_SR  = 8'h01;
  localparam logic [7:0] C_SF  = 8'h02;
  localparam logic [7:0] C_INC = 8'h04;
  localparam logic [7:0] C_CRS = 8'h08;
  localparam logic [7:0] C_CFL = 8'h10;
  localparam logic [7:0] C_SRQ = 8'h20;
  localparam logic [7:0] C_CRQ = 8'h40;
  localparam logic [7:0] C_UPD = 8'h80;

  logic        clk, rst;
  logic        start_rst, start_flush, incr_rst_flush_stalled_set;
  logic        clr_rst_stall, clr_flush_stall, set_req_stall;
  logic [8:0]  stall_set;
  logic [14:0] stall_tag;
  logic [63:0] stall_payload;
  logic        clr_req_stall, update_req_in_from_stalled;
  logic        rst_stall, flush_stall, rst_flush_done, req_stall, req_in_stalled_valid, err;
  logic [8:0]  rst_flush_stalled_set, req_in_stalled_set;
  logic [14:0] req_in_stalled_tag;
  logic [63:0] req_in_stalled_payload;
`ifdef LLC_STALL_STATS_EN
  logic [15:0] stall_cycles;
`endif

  int vectors = 0;
  int miscompares = 0;

  llc_stall_ctrl dut (
    .clk                        (clk),
    .rst                        (rst),
    .start_rst                  (start_rst),
    .start_flush                (start_flush),
    .incr_rst_flush_stalled_set (incr_rst_flush_stalled_set),
    .clr_rst_stall              (clr_rst_stall),
    .clr_flush_stall            (clr_flush_stall),
    .set_req_stall              (set_req_stall),
    .stall_set                  (stall_set),
    .stall_tag                  (stall_tag),
    .stall_payload              (stall_payload),
    .clr_req_stall              (clr_req_stall),
    .update_req_in_from_stalled (update_req_in_from_stalled),
    .rst_stall                  (rst_stall),
    .flush_stall                (flush_stall),
    .rst_flush_stalled_set      (rst_flush_stalled_set),
    .rst_flush_done             (rst_flush_done),
    .req_stall                  (req_stall),
    .req_in_stalled_valid       (req_in_stalled_valid),
    .req_in_stalled_set         (req_in_stalled_set),
    .req_in_stalled_tag         (req_in_stalled_tag),
    .req_in_stalled_payload     (req_in_stalled_payload),
    .err                        (err)
`ifdef LLC_STALL_STATS_EN
    ,
    .stall_cycles               (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  cmd;
    logic [8:0]  set;
    logic [14:0] tag;
    logic [63:0] pl;
    logic        e_rst, e_fl;
    logic [8:0]  e_cnt;
    logic        e_done, e_req, e_val;
    logic [8:0]  e_set;
    logic [14:0] e_tag;
    logic [63:0] e_pl;
    logic        e_err;
  } vec_t;

  // Behavioural model: walk mode 0=none 1=reset 2=flush; request mode 0=free 1=waiting 2=replay
  int          m_walk, m_cnt, m_req, m_stats;
  logic        m_done, m_err;
  logic [8:0]  m_set;
  logic [14:0] m_tag;
  logic [63:0] m_pl;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [7:0] c, input logic [8:0] s, input logic [14:0] t,
                       input logic [63:0] p);
    start_rst                  = c[0];
    start_flush                = c[1];
    incr_rst_flush_stalled_set = c[2];
    clr_rst_stall              = c[3];
    clr_flush_stall            = c[4];
    set_req_stall              = c[5];
    clr_req_stall              = c[6];
    update_req_in_from_stalled = c[7];
    stall_set                  = s;
    stall_tag                  = t;
    stall_payload              = p;
  endtask

  task automatic model_reset();
    m_walk = 0; m_cnt = 0; m_req = 0; m_stats = 0;
    m_done = 0; m_err = 0; m_set = '0; m_tag = '0; m_pl = '0;
  endtask

  task automatic model_step();
    if (m_req == 1 && m_stats < 65535) m_stats++;
    m_done = 0;
    if (m_walk == 0) begin
      if (start_rst) begin
        m_walk = 1; m_cnt = 0;
        if (start_flush) m_err = 1;
      end else if (start_flush) begin
        m_walk = 2; m_cnt = 0;
      end
    end else begin
      if (start_rst || start_flush) m_err = 1;
      if (incr_rst_flush_stalled_set) m_cnt = (m_cnt + 1) % 512;
      if ((m_walk == 1 && clr_rst_stall) || (m_walk == 2 && clr_flush_stall)) begin
        m_walk = 0; m_done = 1;
      end
    end
    if (m_req == 0) begin
      if (set_req_stall) begin
        m_req = 1; m_set = stall_set; m_tag = stall_tag; m_pl = stall_payload;
      end
    end else begin
      if (set_req_stall) m_err = 1;
      if (m_req == 1 && clr_req_stall) m_req = 2;
      else if (m_req == 2 && update_req_in_from_stalled) m_req = 0;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".rst_stall"}, 64'(rst_stall), 64'(m_walk == 1));
    chk({tag, ".flush_stall"}, 64'(flush_stall), 64'(m_walk == 2));
    chk({tag, ".cnt"}, 64'(rst_flush_stalled_set), 64'(m_cnt));
    chk({tag, ".done"}, 64'(rst_flush_done), 64'(m_done));
    chk({tag, ".req_stall"}, 64'(req_stall), 64'(m_req == 1));
    chk({tag, ".valid"}, 64'(req_in_stalled_valid), 64'(m_req == 2));
    chk({tag, ".set"}, 64'(req_in_stalled_set), 64'(m_set));
    chk({tag, ".tag"}, 64'(req_in_stalled_tag), 64'(m_tag));
    chk({tag, ".payload"}, req_in_stalled_payload, m_pl);
    chk({tag, ".err"}, 64'(err), 64'(m_err));
`ifdef LLC_STALL_STATS_EN
    chk({tag, ".stall_cycles"}, 64'(stall_cycles), 64'(m_stats));
`endif
  endtask

  // Inputs are set at the negedge, the DUT samples at posedge, outputs are read at next negedge
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(8'h00, '0, '0, '0);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  vec_t tbl[10];

  initial begin
    tbl[0] = '{C_SF, 9'h0, 15'h0, 64'h0,
               0, 1, 9'd0, 0, 0, 0, 9'h0, 15'h0, 64'h0, 0};
    tbl[1] = '{C_INC, 9'h0, 15'h0, 64'h0,
               0, 1, 9'd1, 0, 0, 0, 9'h0, 15'h0, 64'h0, 0};
    tbl[2] = '{C_INC | C_SRQ, 9'h05A, 15'h1234, 64'hDEAD_BEEF,
               0, 1, 9'd2, 0, 1, 0, 9'h05A, 15'h1234, 64'hDEAD_BEEF, 0};
    tbl[3] = '{C_CRQ | C_CFL, 9'h0, 15'h0, 64'h0,
               0, 0, 9'd2, 1, 0, 1, 9'h05A, 15'h1234, 64'hDEAD_BEEF, 0};
    tbl[4] = '{C_CFL | C_UPD | C_INC, 9'h0, 15'h0, 64'h0,
               0, 0, 9'd2, 0, 0, 0, 9'h05A, 15'h1234, 64'hDEAD_BEEF, 0};
    tbl[5] = '{C_SR, 9'h0, 15'h0, 64'h0,
               1, 0, 9'd0, 0, 0, 0, 9'h05A, 15'h1234, 64'hDEAD_BEEF, 0};
    tbl[6] = '{C_SF | C_INC, 9'h0, 15'h0, 64'h0,
               1, 0, 9'd1, 0, 0, 0, 9'h05A, 15'h1234, 64'hDEAD_BEEF, 1};
    tbl[7] = '{C_SRQ, 9'h001, 15'h0007, 64'h55,
               1, 0, 9'd1, 0, 1, 0, 9'h001, 15'h0007, 64'h55, 1};
    tbl[8] = '{C_SRQ, 9'h05A, 15'h1234, 64'hDEAD_BEEF,
               1, 0, 9'd1, 0, 1, 0, 9'h001, 15'h0007, 64'h55, 1};
    tbl[9] = '{C_CRS | C_CRQ, 9'h0, 15'h0, 64'h0,
               0, 0, 9'd1, 1, 0, 1, 9'h001, 15'h0007, 64'h55, 1};

    rst = 1'b1;
    drive(8'h00, '0, '0, '0);
    @(negedge clk);
    do_reset();
    @(negedge clk);
    check_model("reset");

    // Vector table
    foreach (tbl[i]) begin
      drive(tbl[i].cmd, tbl[i].set, tbl[i].tag, tbl[i].pl);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("tbl%0d.rst_stall", i), 64'(rst_stall), 64'(tbl[i].e_rst));
      chk($sformatf("tbl%0d.flush_stall", i), 64'(flush_stall), 64'(tbl[i].e_fl));
      chk($sformatf("tbl%0d.cnt", i), 64'(rst_flush_stalled_set), 64'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d.done", i), 64'(rst_flush_done), 64'(tbl[i].e_done));
      chk($sformatf("tbl%0d.req_stall", i), 64'(req_stall), 64'(tbl[i].e_req));
      chk($sformatf("tbl%0d.valid", i), 64'(req_in_stalled_valid), 64'(tbl[i].e_val));
      chk($sformatf("tbl%0d.set", i), 64'(req_in_stalled_set), 64'(tbl[i].e_set));
      chk($sformatf("tbl%0d.tag", i), 64'(req_in_stalled_tag), 64'(tbl[i].e_tag));
      chk($sformatf("tbl%0d.payload", i), req_in_stalled_payload, tbl[i].e_pl);
      chk($sformatf("tbl%0d.err", i), 64'(err), 64'(tbl[i].e_err));
    end

    // Full walk: 511 increments, then increment together with clear wraps the counter to 0
    do_reset();
    drive(C_SR, '0, '0, '0);
    cycle();
    check_model("walk.start");
    for (int n = 1; n <= 511; n++) begin
      drive(C_INC, '0, '0, '0);
      cycle();
      chk($sformatf("walk.cnt%0d", n), 64'(rst_flush_stalled_set), 64'(n));
    end
    drive(C_INC | C_CRS, '0, '0, '0);
    cycle();
    chk("walk.wrap_cnt", 64'(rst_flush_stalled_set), 64'd0);
    chk("walk.wrap_rst_stall", 64'(rst_stall), 64'd0);
    chk("walk.wrap_done", 64'(rst_flush_done), 64'd1);
    chk("walk.wrap_err", 64'(err), 64'd0);
    drive(8'h00, '0, '0, '0);
    cycle();
    chk("walk.done_one_cycle", 64'(rst_flush_done), 64'd0);

    // Capture conflict while stalled: buffer keeps the first request, err sticks
    do_reset();
    drive(C_SRQ, 9'h05A, 15'h1234, 64'hDEAD_BEEF);
    cycle();
    drive(C_SRQ, 9'h001, 15'h0001, 64'h1);
    cycle();
    chk("conflict.set", 64'(req_in_stalled_set), 64'h05A);
    chk("conflict.err", 64'(err), 64'd1);
    drive(C_CRQ, '0, '0, '0);
    cycle();
    drive(C_UPD, '0, '0, '0);
    cycle();
    drive(8'h00, '0, '0, '0);
    cycle();
    check_model("conflict.after");
    chk("conflict.err_sticky", 64'(err), 64'd1);

    // Simultaneous starts from idle
    do_reset();
    drive(C_SR | C_SF, '0, '0, '0);
    cycle();
    chk("both_start.rst_stall", 64'(rst_stall), 64'd1);
    chk("both_start.flush_stall", 64'(flush_stall), 64'd0);
    chk("both_start.err", 64'(err), 64'd1);

    // Asynchronous reset mid-walk (count 100) while replaying
    do_reset();
    drive(C_SR | C_SRQ, 9'h0AA, 15'h0BB, 64'hCC);
    cycle();
    drive(C_CRQ, '0, '0, '0);
    cycle();
    for (int n = 0; n < 100; n++) begin
      drive(C_INC, '0, '0, '0);
      cycle();
    end
    drive(8'h00, '0, '0, '0);
    check_model("async.before");
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_model("async.immediate");
    @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < 3; n++) begin
      cycle();
      chk($sformatf("async.no_done%0d", n), 64'(rst_flush_done), 64'd0);
    end

    // Randomized traffic with periodic resets
    for (int seg = 0; seg < 12; seg++) begin
      do_reset();
      for (int n = 0; n < 250; n++) begin
        logic [7:0] c;
        for (int b = 0; b < 8; b++) c[b] = ($urandom_range(0, 99) < 12);
        if ($urandom_range(0, 3) == 0) c[2] = 1'b1;
        drive(c, 9'($urandom), 15'($urandom), {$urandom, $urandom});
        cycle();
        check_model($sformatf("rand%0d_%0d", seg, n));
      end
    end

`ifdef LLC_STALL_STATS_EN
    do_reset();
    drive(C_SRQ, 9'h1, 15'h1, 64'h1);
    cycle();
    drive(8'h00, '0, '0, '0);
    for (int n = 0; n < 70000; n++) @(posedge clk);
    @(negedge clk);
    chk("stats.saturate", 64'(stall_cycles), 64'hFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
